// File: rtl/mul_pkg.sv
// Shared types and elaboration helpers for the iterative multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mul_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Digit size must be a supported radix and tile the operand exactly.
    function automatic bit bpc_legal(input int unsigned width, input int unsigned bpc);
        return ((bpc == 1) || (bpc == 2) || (bpc == 4) || (bpc == 8)) &&
               (width >= 2) && (bpc <= width) && ((width % bpc) == 0);
    endfunction

endpackage

// File: rtl/mul_pp_row.sv
// One partial-product row: magnitude of B times a BITS_PER_CYCLE-bit digit of A.
module mul_pp_row
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH          = 64,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic [WIDTH-1:0]                mcand,
    input  logic [BITS_PER_CYCLE-1:0]       digit,
    output logic [WIDTH+BITS_PER_CYCLE-1:0] row_c
);

    localparam int unsigned RW = WIDTH + BITS_PER_CYCLE;

    assign row_c = RW'(mcand) * RW'(digit);

endmodule

// File: rtl/multiplier_seq_param.sv
// Iterative signed/unsigned multiplier: retires BITS_PER_CYCLE bits of A per cycle
// into a 2*WIDTH accumulator, then applies the sign in a single fix-up cycle.
module multiplier_seq_param
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH          = 64,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = clog2(N) + 1;
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned RW    = WIDTH + BITS_PER_CYCLE;
    localparam int unsigned SH_W  = clog2(PW) + 1;

    if (!bpc_legal(WIDTH, BITS_PER_CYCLE)) begin : g_bad_params
        $error("multiplier_seq_param: illegal WIDTH/BITS_PER_CYCLE combination");
    end

    mul_state_e        state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              neg_q, neg_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]     product_q, product_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic [RW-1:0]     row_c;
    logic [SH_W-1:0]   shamt_c;

    mul_pp_row #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_pp_row (
        .mcand (b_q),
        .digit (a_q[BITS_PER_CYCLE-1:0]),
        .row_c (row_c)
    );

    assign shamt_c = SH_W'(cnt_q) * SH_W'(BITS_PER_CYCLE);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = (in_signed && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
                    b_d     = (in_signed && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;
                    neg_d   = in_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                acc_d = acc_q + (PW'(row_c) << shamt_c);
                a_d   = a_q >> BITS_PER_CYCLE;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                product_d = neg_q ? (~acc_q + PW'(1)) : acc_q;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = busy_q;

endmodule
